debounce_ctrl: RTL and testbench

Time-multiplexed debounce controller: one shared 100 µs tick prescaler and a round-robin scanner sequence the debounce state of N_CH input channels. A single per-channel state update replaces N_CH free-running tick counters, and the block adds change-event interrupt flags. It sits between the raw board inputs (buttons, switches) and the register block that reads filtered levels and services interrupts.

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/debounce_ctrl_if.sv | 35 +++
 rtl/deb_tick_gen.sv | 31 +++
 rtl/debounce_ctrl.sv | 124 ++++++++++++
 tb/tb_debounce_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce controller.
//   scan_state_t : scanner FSM states
//   TICK_W       : prescaler counter width
//   DEB_W        : debounce time / per-channel counter width
//   clog2()      : channel index width (minimum 1 bit)
package debounce_pkg;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

    localparam int unsigned TICK_W = 16;
    localparam int unsigned DEB_W  = 5;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_ctrl_if.sv
// Register-side bus of the debounce controller.
//   ena       : per-channel debounce enable
//   deb_time  : debounce time in ticks, shared by all channels
//   data_in   : raw asynchronous inputs
//   irq_clr   : write-1 clear of irq_pend bits
//   data_out  : filtered levels
//   irq_pend  : sticky "filtered level changed" flags
//   irq       : OR of irq_pend
//   scan_busy : scanner walking channels
// master = stimulus/register side, slave = debounce_ctrl.
interface debounce_ctrl_if
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH = 8
);
    logic [N_CH-1:0]  ena;
    logic [DEB_W-1:0] deb_time;
    logic [N_CH-1:0]  data_in;
    logic [N_CH-1:0]  irq_clr;
    logic [N_CH-1:0]  data_out;
    logic [N_CH-1:0]  irq_pend;
    logic             irq;
    logic             scan_busy;

    modport master (
        output ena, deb_time, data_in, irq_clr,
        input  data_out, irq_pend, irq, scan_busy
    );

    modport slave (
        input  ena, deb_time, data_in, irq_clr,
        output data_out, irq_pend, irq, scan_busy
    );

endinterface

// File: rtl/deb_tick_gen.sv
// Debounce tick prescaler: counts 0..TIME_TICK-1 and wraps.
//   clk_i   : clock
//   res_n_i : synchronous active-low reset
//   tick_o  : one-cycle pulse while the counter sits at TIME_TICK-1
module deb_tick_gen
    import debounce_pkg::*;
#(
    parameter int unsigned TIME_TICK = 10000
) (
    input  logic clk_i,
    input  logic res_n_i,
    output logic tick_o
);

    localparam logic [TICK_W-1:0] LAST_CNT = TICK_W'(TIME_TICK - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;

    assign tick_o     = (tick_cnt_q == LAST_CNT);
    assign tick_cnt_d = tick_o ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/debounce_ctrl.sv
// Time-multiplexed debounce controller. One shared prescaler tick starts a
// round-robin scan that updates one channel per cycle, committing a new
// filtered level once a mismatch has persisted for deb_time+1 scans.
//   clk   : clock
//   res_n : synchronous active-low reset
//   bus   : register-side bus (see debounce_ctrl_if)
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned TIME_TICK = 10000
) (
    input  logic            clk,
    input  logic            res_n,
    debounce_ctrl_if.slave  bus
);

    localparam int unsigned       CH_W    = clog2(N_CH);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

    logic              tick;
    logic [N_CH-1:0]   sync1_q;
    logic [N_CH-1:0]   din_s_q;
    scan_state_t       state_q;
    logic [CH_W-1:0]   ch_q;
    logic [N_CH-1:0]   filt_q;
    logic [DEB_W-1:0]  cnt_q [N_CH];
    logic [N_CH-1:0]   irq_pend_q;

    // Next state of the channel currently under the scanner.
    logic              din_cur;
    logic              filt_cur;
    logic              ena_cur;
    logic [DEB_W-1:0]  cnt_cur;
    logic              filt_d;
    logic [DEB_W-1:0]  cnt_d;
    logic              commit_d;
    logic [N_CH-1:0]   set_d;
    logic [N_CH-1:0]   irq_pend_d;

    deb_tick_gen #(
        .TIME_TICK (TIME_TICK)
    ) u_tick_gen (
        .clk_i   (clk),
        .res_n_i (res_n),
        .tick_o  (tick)
    );

    always_comb begin
        din_cur  = din_s_q[ch_q];
        filt_cur = filt_q[ch_q];
        ena_cur  = bus.ena[ch_q];
        cnt_cur  = cnt_q[ch_q];
        filt_d   = filt_cur;
        cnt_d    = cnt_cur;
        commit_d = 1'b0;
        if (!ena_cur) begin
            cnt_d  = '0;
            filt_d = din_cur;
        end else if (din_cur == filt_cur) begin
            cnt_d = '0;
        end else if (cnt_cur >= bus.deb_time) begin
            // >= (not ==) so a shortened deb_time commits on the next scan
            filt_d   = din_cur;
            cnt_d    = '0;
            commit_d = 1'b1;
        end else begin
            cnt_d = cnt_cur + 1'b1;
        end

        set_d = '0;
        if ((state_q == S_SCAN) && commit_d) begin
            set_d[ch_q] = 1'b1;
        end
        // A commit in the same cycle as a clear keeps the flag set.
        irq_pend_d = (irq_pend_q & ~bus.irq_clr) | set_d;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            sync1_q    <= '0;
            din_s_q    <= '0;
            state_q    <= S_IDLE;
            ch_q       <= '0;
            filt_q     <= '0;
            irq_pend_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= bus.data_in;
            din_s_q    <= sync1_q;
            irq_pend_q <= irq_pend_d;
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_SCAN;
                        ch_q    <= '0;
                    end
                end
                S_SCAN: begin
                    filt_q[ch_q] <= filt_d;
                    cnt_q[ch_q]  <= cnt_d;
                    if (ch_q == LAST_CH) begin
                        state_q <= S_IDLE;
                        ch_q    <= '0;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ch_q    <= '0;
                end
            endcase
        end
    end

    assign bus.data_out  = (bus.ena & filt_q) | (~bus.ena & din_s_q);
    assign bus.irq_pend  = irq_pend_q;
    assign bus.irq       = |irq_pend_q;
    assign bus.scan_busy = (state_q == S_SCAN);

endmodule

// File: tb/tb_debounce_ctrl.sv
// Self-checking bench for debounce_ctrl (N_CH=4, TIME_TICK=20). A reference
// model derives scan timing from the edge count since reset (tick every 20
// edges, channel i handled i+1 edges after each tick) and applies the
// debounce rules per channel.
module tb_debounce_ctrl;

    localparam int N  = 4;
    localparam int TT = 20;

    logic clk;
    logic res_n;

    debounce_ctrl_if #(.N_CH(N)) bus_if ();

    debounce_ctrl #(
        .N_CH      (N),
        .TIME_TICK (TT)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [N-1:0] s1_m, s2_m, filt_m, pend_m;
    int           cnt_m [N];
    int           k_m;
    bit           busy_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h (edge %0d)", tag, got, exp, k_m);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] din;
        logic [N-1:0] set;
        int           i;
        if (!res_n) begin
            s1_m = '0; s2_m = '0; filt_m = '0; pend_m = '0;
            for (int c = 0; c < N; c++) cnt_m[c] = 0;
            k_m = 0;
            busy_m = 0;
        end else begin
            din = s2_m;
            set = '0;
            if (k_m >= TT && (k_m % TT) < N) begin
                i = k_m % TT;
                if (!bus_if.ena[i]) begin
                    cnt_m[i] = 0;
                    filt_m[i] = din[i];
                end else if (din[i] == filt_m[i]) begin
                    cnt_m[i] = 0;
                end else if (cnt_m[i] >= int'(bus_if.deb_time)) begin
                    filt_m[i] = din[i];
                    cnt_m[i] = 0;
                    set[i] = 1'b1;
                end else begin
                    cnt_m[i] = cnt_m[i] + 1;
                end
            end
            pend_m = (pend_m & ~bus_if.irq_clr) | set;
            busy_m = (k_m >= TT - 1) && (((k_m + 1) % TT) < N);
            s2_m = s1_m;
            s1_m = bus_if.data_in;
            k_m++;
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_out;
        @(posedge clk);
        model_edge();
        #1;
        exp_out = (bus_if.ena & filt_m) | (~bus_if.ena & s2_m);
        chk("data_out",  32'(bus_if.data_out),  32'(exp_out));
        chk("irq_pend",  32'(bus_if.irq_pend),  32'(pend_m));
        chk("irq",       32'(bus_if.irq),       32'(|pend_m));
        chk("scan_busy", 32'(bus_if.scan_busy), 32'(busy_m));
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    // Advance until the next edge to be applied has index == p (mod TT).
    task automatic wait_phase(input int p);
        for (int j = 0; j < TT && (k_m % TT) != p; j++) step();
    endtask

    task automatic clr_pulse(input logic [N-1:0] m);
        bus_if.irq_clr = m;
        step();
        bus_if.irq_clr = '0;
    endtask

    initial begin
        int idx;
        res_n = 1'b0;
        k_m = 0;
        bus_if.ena      = 4'($urandom);
        bus_if.deb_time = 5'($urandom);
        bus_if.data_in  = 4'($urandom);
        bus_if.irq_clr  = 4'($urandom);

        // Reset with random inputs
        run(3);
        chk("rst_data_out",  32'(bus_if.data_out),  32'd0);
        chk("rst_irq_pend",  32'(bus_if.irq_pend),  32'd0);
        chk("rst_irq",       32'(bus_if.irq),       32'd0);
        chk("rst_scan_busy", 32'(bus_if.scan_busy), 32'd0);

        bus_if.ena      = 4'b1111;
        bus_if.deb_time = 5'd2;
        bus_if.data_in  = 4'b0000;
        bus_if.irq_clr  = 4'b0000;
        res_n = 1'b1;

        // First tick: scanner starts after the 20th edge following release
        run(TT - 1);
        chk("pre_tick_busy", 32'(bus_if.scan_busy), 32'd0);
        step();
        chk("first_tick_busy", 32'(bus_if.scan_busy), 32'd1);

        // Clean edge on channel 1
        run(10);
        bus_if.data_in[1] = 1'b1;
        run(100);
        chk("clean_data_out1", 32'(bus_if.data_out[1]), 32'd1);
        chk("clean_irq_pend",  32'(bus_if.irq_pend),    32'b0010);
        chk("clean_irq",       32'(bus_if.irq),         32'd1);
        clr_pulse(4'b0010);
        chk("clean_cleared",   32'(bus_if.irq_pend),    32'd0);

        // Bounce on channel 2 with deb_time=3
        bus_if.deb_time = 5'd3;
        wait_phase(5);
        bus_if.data_in[2] = 1'b1;
        run(2 * TT);
        bus_if.data_in[2] = 1'b0;
        run(TT);
        bus_if.data_in[2] = 1'b1;
        run(3 * TT);
        chk("bounce_not_yet",  32'(bus_if.data_out[2]), 32'd0);
        chk("bounce_no_irq",   32'(bus_if.irq_pend),    32'd0);
        run(TT);
        chk("bounce_commit",   32'(bus_if.data_out[2]), 32'd1);
        chk("bounce_irq_pend", 32'(bus_if.irq_pend),    32'b0100);
        clr_pulse(4'b0100);

        // Disabled channel 0 follows din_s after the synchronizer
        bus_if.ena = 4'b1110;
        for (int t = 0; t < 4; t++) begin
            bus_if.data_in[0] = ~bus_if.data_in[0];
            run(2);
            chk("dis_follow", 32'(bus_if.data_out[0]), 32'(bus_if.data_in[0]));
            run(13);
        end
        run(2 * TT);
        bus_if.ena = 4'b1111;
        run(3 * TT);
        chk("dis_no_irq", 32'(bus_if.irq_pend[0]), 32'd0);

        // Set/clear collision on channel 3 with deb_time=0
        bus_if.deb_time = 5'd0;
        wait_phase(0);
        bus_if.data_in[3] = 1'b1;
        run(3);
        bus_if.irq_clr = 4'b1000;
        step();
        bus_if.irq_clr = 4'b0000;
        chk("coll_set_wins", 32'(bus_if.irq_pend[3]), 32'd1);
        chk("coll_data_out", 32'(bus_if.data_out[3]), 32'd1);
        run(2);
        clr_pulse(4'b1000);
        chk("coll_cleared", 32'(bus_if.irq_pend[3]), 32'd0);

        // deb_time reduction mid-count on channel 0
        bus_if.data_in[0] = 1'b0;
        run(2 * TT);
        clr_pulse(4'b1111);
        bus_if.deb_time = 5'd10;
        wait_phase(5);
        bus_if.data_in[0] = 1'b1;
        run(4 * TT);
        chk("dt10_hold", 32'(bus_if.data_out[0]), 32'd0);
        bus_if.deb_time = 5'd1;
        run(TT);
        chk("dt1_commit", 32'(bus_if.data_out[0]), 32'd1);
        bus_if.deb_time = 5'd0;
        bus_if.data_in[0] = 1'b0;
        run(TT);
        chk("dt0_commit", 32'(bus_if.data_out[0]), 32'd0);
        clr_pulse(4'b1111);

        // Reset asserted mid-scan
        bus_if.data_in = 4'b1010;
        bus_if.deb_time = 5'd0;
        run(TT);
        wait_phase(1);
        res_n = 1'b0;
        run(2);
        chk("midrst_data_out", 32'(bus_if.data_out),  32'd0);
        chk("midrst_irq_pend", 32'(bus_if.irq_pend),  32'd0);
        chk("midrst_busy",     32'(bus_if.scan_busy), 32'd0);
        res_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                bus_if.data_in[idx] = ~bus_if.data_in[idx];
            end
            if ($urandom_range(0, 199) == 0) bus_if.ena = 4'($urandom);
            if ($urandom_range(0, 299) == 0) bus_if.deb_time = 5'($urandom_range(0, 3));
            bus_if.irq_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 999) == 0) res_n = 1'b0;
            else res_n = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
